fib_sequencer: RTL and testbench

Initiator-side controller for the fibonacci core. It drives the core's din/start/reset inputs and consumes its dout/done.
On a go pulse it sweeps indices 0..num_tests-1, one request per index. Each returned result is checked against an internal reference recurrence, and pass/fail/timeout/latency status is reported.
It sits between a host/status block and one fibonacci instance, replacing the software loop used in simulation with synthesizable hardware.

---
 rtl/fib_pkg.sv | 23 ++
 rtl/fib_sequencer_if.sv | 23 ++
 rtl/fib_model.sv | 28 ++
 rtl/fib_sequencer.sv | 147 ++++++++++++++
 tb/tb_fib_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the fibonacci sequencer: default data width,
// controller state encoding and a saturating 8-bit increment.
package fib_pkg;

   localparam int FIB_WIDTH = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLR,
      ST_GAP,
      ST_ISSUE,
      ST_WAIT,
      ST_CHECK,
      ST_HOLD,
      ST_ADV,
      ST_DONE
   } fib_seq_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fib_sequencer_if.sv
// Request/response link between the sequencer (master) and one
// fibonacci core (slave).
interface fib_sequencer_if
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH
);
   logic             core_clr;
   logic [WIDTH-1:0] req_n;
   logic             req_start;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_done;

   modport master (
      output core_clr, req_n, req_start,
      input  rsp_data, rsp_done
   );

   modport slave (
      input  core_clr, req_n, req_start,
      output rsp_data, rsp_done
   );
endinterface

// File: rtl/fib_model.sv
// Reference fibonacci recurrence; r0 holds F(k) after k advances,
// wrapping modulo 2^WIDTH.
module fib_model
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             adv,
   output logic [WIDTH-1:0] r0
);
   logic [WIDTH-1:0] r1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r0 <= '0;
         r1 <= WIDTH'(1);
      end else if (clr) begin
         r0 <= '0;
         r1 <= WIDTH'(1);
      end else if (adv) begin
         r0 <= r1;
         r1 <= r0 + r1;
      end
   end
endmodule

// File: rtl/fib_sequencer.sv
// Drives a fibonacci core through indices 0..num_tests-1 and scores each
// result against fib_model, reporting pass/fail/timeout/latency status.
module fib_sequencer
   import fib_pkg::*;
#(
   parameter int WIDTH       = FIB_WIDTH,
   parameter int TIMEOUT     = 1024,
   parameter int HOLD_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            go,
   input  logic [7:0]      num_tests,
   fib_sequencer_if.master core,
   output logic            busy,
   output logic            finished,
   output logic [7:0]      pass_cnt,
   output logic [7:0]      fail_cnt,
   output logic            timeout_err,
   output logic [7:0]      first_fail_idx,
   output logic [15:0]     last_cycles
);
   fib_seq_state_t   state;
   logic [7:0]       idx;
   logic [7:0]       num_latched;
   logic [7:0]       hold_cnt;
   logic [15:0]      cyc_cnt;
   logic             core_clr_reg;
   logic             req_start_reg;
   logic [WIDTH-1:0] req_n_reg;
   logic             go_accept;
   logic             last_idx;
   logic [WIDTH-1:0] model_r0;

   assign go_accept = go && (state == ST_IDLE || state == ST_DONE);
   assign last_idx  = (({1'b0, idx} + 9'd1) == {1'b0, num_latched});

   assign core.core_clr  = core_clr_reg;
   assign core.req_start = req_start_reg;
   assign core.req_n     = req_n_reg;

   fib_model #(.WIDTH(WIDTH)) u_model (
      .clk   (clk),
      .reset (reset),
      .clr   (go_accept),
      .adv   (state == ST_ADV),
      .r0    (model_r0)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         core_clr_reg   <= 1'b0;
         req_start_reg  <= 1'b0;
         req_n_reg      <= '0;
         busy           <= 1'b0;
         finished       <= 1'b0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         timeout_err    <= 1'b0;
         first_fail_idx <= '0;
         last_cycles    <= '0;
         idx            <= '0;
         num_latched    <= '0;
         hold_cnt       <= '0;
         cyc_cnt        <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (go) begin
                  pass_cnt       <= '0;
                  fail_cnt       <= '0;
                  timeout_err    <= 1'b0;
                  first_fail_idx <= '0;
                  last_cycles    <= '0;
                  idx            <= '0;
                  num_latched    <= num_tests;
                  if (num_tests == 8'd0) begin
                     state    <= ST_DONE;
                     finished <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     state        <= ST_CLR;
                     core_clr_reg <= 1'b1;
                     finished     <= 1'b0;
                     busy         <= 1'b1;
                  end
               end
            end
            ST_CLR: begin
               core_clr_reg <= 1'b0;
               state        <= ST_GAP;
            end
            ST_GAP: begin
               req_start_reg <= 1'b1;
               req_n_reg     <= WIDTH'(idx);
               state         <= ST_ISSUE;
            end
            ST_ISSUE: begin
               req_start_reg <= 1'b0;
               cyc_cnt       <= 16'd1;
               state         <= ST_WAIT;
            end
            ST_WAIT: begin
               if (core.rsp_done) begin
                  last_cycles <= cyc_cnt;
                  state       <= ST_CHECK;
               end else if (cyc_cnt >= 16'(TIMEOUT)) begin
                  timeout_err <= 1'b1;
                  fail_cnt    <= sat_inc8(fail_cnt);
                  if (fail_cnt == 8'd0) first_fail_idx <= idx;
                  hold_cnt    <= 8'(HOLD_CYCLES - 1);
                  state       <= (HOLD_CYCLES == 0) ? ST_ADV : ST_HOLD;
               end else begin
                  cyc_cnt <= cyc_cnt + 16'd1;
               end
            end
            ST_CHECK: begin
               if (core.rsp_data == model_r0) begin
                  pass_cnt <= sat_inc8(pass_cnt);
               end else begin
                  fail_cnt <= sat_inc8(fail_cnt);
                  if (fail_cnt == 8'd0) first_fail_idx <= idx;
               end
               hold_cnt <= 8'(HOLD_CYCLES - 1);
               state    <= (HOLD_CYCLES == 0) ? ST_ADV : ST_HOLD;
            end
            ST_HOLD: begin
               if (hold_cnt == 8'd0) state <= ST_ADV;
               else                  hold_cnt <= hold_cnt - 8'd1;
            end
            ST_ADV: begin
               idx <= idx + 8'd1;
               if (last_idx) begin
                  state    <= ST_DONE;
                  finished <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  state        <= ST_CLR;
                  core_clr_reg <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fib_sequencer.sv
// Randomized scoreboard bench: a behavioural core stub answers requests,
// expected request order and end-of-sweep status are queued and checked.
module tb_fib_sequencer;
   import fib_pkg::*;

   localparam int W  = 16;
   localparam int TO = 64;
   localparam int HC = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        go = 1'b0;
   logic [7:0]  num_tests = 8'd0;
   logic        busy, finished, timeout_err;
   logic [7:0]  pass_cnt, fail_cnt, first_fail_idx;
   logic [15:0] last_cycles;

   fib_sequencer_if #(.WIDTH(W)) core_bus();

   fib_sequencer #(.WIDTH(W), .TIMEOUT(TO), .HOLD_CYCLES(HC)) dut (
      .clk            (clk),
      .reset          (reset),
      .go             (go),
      .num_tests      (num_tests),
      .core           (core_bus),
      .busy           (busy),
      .finished       (finished),
      .pass_cnt       (pass_cnt),
      .fail_cnt       (fail_cnt),
      .timeout_err    (timeout_err),
      .first_fail_idx (first_fail_idx),
      .last_cycles    (last_cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  pass;
      logic [7:0]  fail;
      logic        tmo;
      logic [7:0]  ffi;
      logic [15:0] lastc;
   } summary_t;

   logic [W-1:0] req_q[$];
   summary_t     sum_q[$];
   int           checks = 0;
   int           failures = 0;

   int lat_cfg[256];
   bit bad_cfg[256];
   bit hang_cfg[256];

   function automatic logic [W-1:0] fib_ref(input int n);
      logic [W-1:0] a, b, t;
      a = '0;
      b = W'(1);
      for (int k = 0; k < n; k++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Behavioural core: answers after lat_cfg[n] cycles, optionally wrong or silent
   logic [W-1:0] stub_data = '0;
   logic         stub_done = 1'b0;
   bit           stub_active = 1'b0;
   int           stub_cnt = 0;
   int           stub_lat = 1;

   assign core_bus.rsp_data = stub_data;
   assign core_bus.rsp_done = stub_done;

   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (!reset || core_bus.core_clr) begin
         stub_active <= 1'b0;
         stub_cnt    <= 0;
         stub_data   <= '0;
      end else if (core_bus.req_start) begin
         stub_data   <= fib_ref(int'(core_bus.req_n)) + W'(bad_cfg[core_bus.req_n[7:0]] ? 1 : 0);
         stub_lat    <= lat_cfg[core_bus.req_n[7:0]];
         stub_cnt    <= 1;
         stub_active <= !hang_cfg[core_bus.req_n[7:0]] && (lat_cfg[core_bus.req_n[7:0]] > 1);
         stub_done   <= !hang_cfg[core_bus.req_n[7:0]] && (lat_cfg[core_bus.req_n[7:0]] == 1);
      end else if (stub_active) begin
         stub_cnt <= stub_cnt + 1;
         if (stub_cnt + 1 == stub_lat) begin
            stub_done   <= 1'b1;
            stub_active <= 1'b0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a request or a finished sweep
   bit prev_start = 1'b0;
   int cyc = 0;
   int last_clr = -100;

   always @(negedge clk) begin
      if (!reset) begin
         prev_start <= 1'b0;
      end else begin
         cyc        <= cyc + 1;
         prev_start <= core_bus.req_start;
         if (core_bus.core_clr) begin
            check("clr_while_expected", 32'(req_q.size() != 0), 1);
            last_clr <= cyc;
         end
         if (core_bus.req_start) begin
            check("start_width", 32'(prev_start), 0);
            check("clr_to_start", 32'(cyc - last_clr), 2);
            if (req_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL req_unexpected actual req_n=%0d required=no request", core_bus.req_n);
            end else begin
               $display("req n=%0d expected=%0d", core_bus.req_n, req_q[0]);
               check("req_n", 32'(core_bus.req_n), 32'(req_q[0]));
               void'(req_q.pop_front());
            end
         end
         if (finished && sum_q.size() != 0) begin
            $display("sweep done pass=%0d fail=%0d tmo=%0d ffi=%0d last=%0d",
                     pass_cnt, fail_cnt, timeout_err, first_fail_idx, last_cycles);
            check("pass_cnt",       32'(pass_cnt),       32'(sum_q[0].pass));
            check("fail_cnt",       32'(fail_cnt),       32'(sum_q[0].fail));
            check("timeout_err",    32'(timeout_err),    32'(sum_q[0].tmo));
            check("first_fail_idx", 32'(first_fail_idx), 32'(sum_q[0].ffi));
            check("last_cycles",    32'(last_cycles),    32'(sum_q[0].lastc));
            check("busy_at_done",   32'(busy),           0);
            void'(sum_q.pop_front());
         end
      end
   end

   // bad_idx: -1 none, -2 random, else that index; fixed_lat 0 = random 1..20
   task automatic plan_sweep(input int n, input int hang_idx, input int bad_idx,
                             input int fixed_lat, output summary_t s);
      int p, f;
      p = 0;
      f = 0;
      s = '0;
      for (int i = 0; i < 256; i++) begin
         lat_cfg[i]  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
         bad_cfg[i]  = (bad_idx == -2) ? ($urandom_range(0, 7) == 0) : (i == bad_idx);
         hang_cfg[i] = (i == hang_idx);
      end
      for (int i = 0; i < n; i++) begin
         req_q.push_back(W'(i));
         if (hang_cfg[i]) begin
            s.tmo = 1'b1;
            if (f == 0) s.ffi = 8'(i);
            f++;
         end else begin
            s.lastc = 16'(lat_cfg[i]);
            if (bad_cfg[i]) begin
               if (f == 0) s.ffi = 8'(i);
               f++;
            end else begin
               p++;
            end
         end
      end
      s.pass = 8'((p > 255) ? 255 : p);
      s.fail = 8'((f > 255) ? 255 : f);
   endtask

   task automatic start_sweep(input int n, input summary_t s);
      @(posedge clk);
      #1 num_tests = 8'(n);
      go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      sum_q.push_back(s);
   endtask

   task automatic finish_sweep(input string name);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (finished) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=not finished required=finished", name);
         req_q.delete();
         sum_q.delete();
      end
      @(negedge clk);
      check({name, "_drain"}, 32'(req_q.size() + sum_q.size()), 0);
   endtask

   task automatic run_sweep(input string name, input int n, input int hang_idx,
                            input int bad_idx, input int fixed_lat, input bit glitch);
      summary_t s;
      plan_sweep(n, hang_idx, bad_idx, fixed_lat, s);
      start_sweep(n, s);
      if (glitch) begin
         repeat (30) @(posedge clk);
         #1 go = 1'b1;
         num_tests = 8'd3;
         @(posedge clk);
         #1 go = 1'b0;
      end
      finish_sweep(name);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},        32'(busy), 0);
      check({tag, "_finished"},    32'(finished), 0);
      check({tag, "_pass"},        32'(pass_cnt), 0);
      check({tag, "_fail"},        32'(fail_cnt), 0);
      check({tag, "_tmo"},         32'(timeout_err), 0);
      check({tag, "_ffi"},         32'(first_fail_idx), 0);
      check({tag, "_last"},        32'(last_cycles), 0);
      check({tag, "_core_clr"},    32'(core_bus.core_clr), 0);
      check({tag, "_req_start"},   32'(core_bus.req_start), 0);
      check({tag, "_req_n"},       32'(core_bus.req_n), 0);
   endtask

   initial begin
      summary_t s;
      bit got;
      #2 check_zero("reset");
      @(posedge clk);
      #1 reset = 1'b1;

      run_sweep("all_good", 25, -1, -1, 0, 1'b0);
      run_sweep("zero", 0, -1, -1, 0, 1'b0);
      run_sweep("bad7", 10, -1, 7, 0, 1'b0);
      run_sweep("hang3", 6, 3, -1, 0, 1'b0);
      run_sweep("lat5_go_ignored", 12, -1, -1, 5, 1'b1);

      // Reset while waiting on index 5 of a sweep
      plan_sweep(10, -1, -1, 3, s);
      lat_cfg[5] = 40;
      start_sweep(10, s);
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (core_bus.req_start && core_bus.req_n == W'(5)) begin
            got = 1'b1;
            break;
         end
      end
      check("reach_idx5", 32'(got), 1);
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      #1 check_zero("mid_reset");
      req_q.delete();
      sum_q.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      run_sweep("after_reset", 6, -1, -2, 0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         int n;
         n = int'($urandom_range(1, 60));
         run_sweep("random", n, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1,
                   -2, 0, n >= 10);
      end
      run_sweep("full_wrap", 255, -1, -2, 1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_time_limit actual=expired required=finish");
      $fatal(1, "time limit");
   end
endmodule
